lzw_code_packer: RTL and testbench

- Downstream stage of the LZW compressor. Accepts a stream of fixed-width LZW codes (12-bit by default) over a valid/ready handshake.
- Packs the codes into a dense byte stream, MSB-first, with no gaps between codes.
- On the last code it drains the remaining bits, zero-pads the final partial byte and flags it with last_o.
- Feeds the byte-wide output/transport path.

---
 rtl/lzw_code_packer_if.sv | 26 ++
 rtl/lzw_code_packer.sv | 85 ++++++++
 tb/tb_lzw_code_packer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzw_code_packer_if.sv
// Handshake bundle between the LZW compressor, the code packer and the byte sink.
// The packer connects through the slave modport; the code source / byte sink side uses master.
interface lzw_code_packer_if #(
  parameter int CODE_W = 12,
  parameter int CNT_W  = 16
);
  logic [CODE_W-1:0] code_i;
  logic              code_valid_i;
  logic              code_last_i;
  logic              code_ready_o;
  logic [7:0]        byte_o;
  logic              byte_valid_o;
  logic              byte_ready_i;
  logic              byte_last_o;
  logic [CNT_W-1:0]  byte_count_o;

  modport master (
    output code_i, code_valid_i, code_last_i, byte_ready_i,
    input  code_ready_o, byte_o, byte_valid_o, byte_last_o, byte_count_o
  );

  modport slave (
    input  code_i, code_valid_i, code_last_i, byte_ready_i,
    output code_ready_o, byte_o, byte_valid_o, byte_last_o, byte_count_o
  );
endinterface

// File: rtl/lzw_code_packer.sv
// Packs fixed-width LZW codes into a dense, gap-free byte stream (MSB-first by default).
// Define LZW_PACK_LSB_FIRST_EN for LSB-first (GIF-style) packing.
module lzw_code_packer #(
  parameter int CODE_W = 12,
  parameter int CNT_W  = 16
) (
  input logic              clk_i,
  input logic              reset_i,
  lzw_code_packer_if.slave bus
);
  localparam int ACC_W = CODE_W + 7;
  localparam int BC_W  = $clog2(ACC_W + 1);
  localparam logic [BC_W-1:0] CODE_BITS = BC_W'(CODE_W);
  localparam logic [BC_W-1:0] BYTE_BITS = BC_W'(8);
  localparam logic [BC_W-1:0] NO_BITS   = '0;

  typedef enum logic {ACCEPT, DRAIN} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, ins_bits, acc_shift;
  logic [BC_W-1:0]  bit_cnt, cnt_nx;
  logic [7:0]       byte_q, byte_nx;
  logic             code_ready_q, byte_valid_q, byte_last_q;
  logic [CNT_W-1:0] byte_count_q;
  logic             code_hs, byte_hs;

  // Accepts happen only below 8 valid bits, so the new code always fits in acc.
`ifdef LZW_PACK_LSB_FIRST_EN
  assign ins_bits  = {7'b0, bus.code_i} << bit_cnt;
  assign acc_shift = acc >> 8;
  assign byte_nx   = acc_nx[7:0];
`else
  assign ins_bits  = {bus.code_i, 7'b0} >> bit_cnt;
  assign acc_shift = acc << 8;
  assign byte_nx   = acc_nx[ACC_W-1 -: 8];
`endif

  assign code_hs = bus.code_valid_i & code_ready_q;
  assign byte_hs = byte_valid_q & bus.byte_ready_i;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = bit_cnt;
    if (code_hs) begin
      acc_nx = acc | ins_bits;
      cnt_nx = bit_cnt + CODE_BITS;
      if (bus.code_last_i) state_nx = DRAIN;
    end else if (byte_hs) begin
      acc_nx = acc_shift;
      cnt_nx = (bit_cnt > BYTE_BITS) ? (bit_cnt - BYTE_BITS) : NO_BITS;
      if ((state == DRAIN) && (bit_cnt <= BYTE_BITS)) state_nx = ACCEPT;
    end
  end

  // Handshake flags and the output byte are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state        <= ACCEPT;
      acc          <= '0;
      bit_cnt      <= NO_BITS;
      byte_count_q <= '0;
      code_ready_q <= 1'b1;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      byte_q       <= 8'h00;
    end else begin
      state        <= state_nx;
      acc          <= acc_nx;
      bit_cnt      <= cnt_nx;
      if (byte_hs) byte_count_q <= byte_count_q + CNT_W'(1);
      code_ready_q <= (state_nx == ACCEPT) && (cnt_nx < BYTE_BITS);
      byte_valid_q <= (cnt_nx >= BYTE_BITS) || ((state_nx == DRAIN) && (cnt_nx != NO_BITS));
      byte_last_q  <= (state_nx == DRAIN) && (cnt_nx != NO_BITS) && (cnt_nx <= BYTE_BITS);
      byte_q       <= byte_nx;
    end
  end

  // Handshake outputs are forced quiet for the whole time reset is held.
  assign bus.code_ready_o = reset_i & code_ready_q;
  assign bus.byte_valid_o = reset_i & byte_valid_q;
  assign bus.byte_last_o  = reset_i & byte_last_q;
  assign bus.byte_o       = reset_i ? byte_q : 8'h00;
  assign bus.byte_count_o = byte_count_q;
endmodule

// File: tb/tb_lzw_code_packer.sv
// Self-checking bench for lzw_code_packer: literal vector table plus a bit-level
// packing model feeding a byte scoreboard. Honours LZW_PACK_LSB_FIRST_EN.
module tb_lzw_code_packer;
  localparam int CODE_W = 12;
  localparam int CNT_W  = 10;
  localparam int WRAP_STREAMS = 342;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic [3:0]            ncodes;
    logic [0:2][11:0]      codes;
    logic [3:0]            nbytes;
    logic [0:4][7:0]       bytes;
    logic [1:0]            mode;
  } vec_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  int checks = 0;
  int failures = 0;
  int toggle_mode = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [CNT_W-1:0] exp_count = '0;
  logic stalled = 1'b0;
  logic [7:0] held_byte = 8'h00;
  logic held_last = 1'b0;
  vec_t vec[4];

  lzw_code_packer_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

  lzw_code_packer #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sampled on the falling edge, so the handshake seen here completes at the next rise.
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (stalled) begin
        checkOutput("hold_valid", {31'b0, bus.byte_valid_o}, 32'd1);
        checkOutput("hold_byte", {24'b0, bus.byte_o}, {24'b0, held_byte});
        checkOutput("hold_last", {31'b0, bus.byte_last_o}, {31'b0, held_last});
      end
      checkOutput("ready_valid_exclusive", {31'b0, bus.code_ready_o & bus.byte_valid_o}, 32'd0);
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", bus.byte_o, $time);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("byte_data", {24'b0, bus.byte_o}, {24'b0, mon_e.data});
          checkOutput("byte_last", {31'b0, bus.byte_last_o}, {31'b0, mon_e.last});
        end
        exp_count = exp_count + 1'b1;
      end
      stalled   = bus.byte_valid_o && !bus.byte_ready_i;
      held_byte = bus.byte_o;
      held_last = bus.byte_last_o;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
    if (toggle_mode == 1) bus.byte_ready_i = ~bus.byte_ready_i;
    else if (toggle_mode == 2) bus.byte_ready_i = 1'($urandom_range(0, 1));
    else bus.byte_ready_i = 1'b1;
  endtask

  task automatic applyStimulus(input logic [CODE_W-1:0] code, input logic last);
    logic hs;
    int budget;
    budget = 0;
    hs = 1'b0;
    bus.code_i       = code;
    bus.code_valid_i = 1'b1;
    bus.code_last_i  = last;
    while (!hs && budget < 200) begin
      @(negedge clk_i);
      hs = bus.code_ready_o;
      stepCycle();
      budget++;
    end
    checkOutput("code_accept_timeout", {31'b0, hs}, 32'd1);
    bus.code_valid_i = 1'b0;
    bus.code_last_i  = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (sbq.size() != 0 && budget < 400) begin
      stepCycle();
      budget++;
    end
    checkOutput("drain_timeout", sbq.size(), 32'd0);
    toggle_mode = 0;
    bus.byte_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle_valid", {31'b0, bus.byte_valid_o}, 32'd0);
    checkOutput("idle_code_ready", {31'b0, bus.code_ready_o}, 32'd1);
    checkOutput("byte_count", {22'b0, bus.byte_count_o}, {22'b0, exp_count});
    @(posedge clk_i);
    #1;
  endtask

  task automatic resetDut();
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_code_ready", {31'b0, bus.code_ready_o}, 32'd0);
    checkOutput("rst_byte_valid", {31'b0, bus.byte_valid_o}, 32'd0);
    checkOutput("rst_byte", {24'b0, bus.byte_o}, 32'd0);
    checkOutput("rst_byte_last", {31'b0, bus.byte_last_o}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    sbq.delete();
    exp_count = '0;
    @(negedge clk_i);
    checkOutput("post_rst_valid", {31'b0, bus.byte_valid_o}, 32'd0);
    checkOutput("post_rst_code_ready", {31'b0, bus.code_ready_o}, 32'd1);
    checkOutput("post_rst_count", {22'b0, bus.byte_count_o}, 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Reference packer: walks the concatenated code bit stream and zero-pads the tail.
  task automatic pushModel(input logic [CODE_W-1:0] cq[$]);
    int total;
    int nb;
    exp_t e;
    total = cq.size() * CODE_W;
    nb = (total + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      e.data = 8'h00;
      for (int k = 0; k < 8; k++) begin
        int pos;
        pos = i * 8 + k;
        if (pos < total) begin
`ifdef LZW_PACK_LSB_FIRST_EN
          e.data[k] = cq[pos / CODE_W][pos % CODE_W];
`else
          e.data[7 - k] = cq[pos / CODE_W][CODE_W - 1 - (pos % CODE_W)];
`endif
        end
      end
      e.last = (i == nb - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic runVector(input int v);
    exp_t e;
    toggle_mode = int'(vec[v].mode);
    bus.byte_ready_i = 1'b1;
    for (int b = 0; b < int'(vec[v].nbytes); b++) begin
      e.data = vec[v].bytes[b];
      e.last = (b == int'(vec[v].nbytes) - 1);
      sbq.push_back(e);
    end
    for (int c = 0; c < int'(vec[v].ncodes); c++)
      applyStimulus(vec[v].codes[c], c == int'(vec[v].ncodes) - 1);
    waitDrain();
  endtask

  initial begin
    #1000000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [CODE_W-1:0] cq[$];
    bus.code_i       = '0;
    bus.code_valid_i = 1'b0;
    bus.code_last_i  = 1'b0;
    bus.byte_ready_i = 1'b1;

`ifdef LZW_PACK_LSB_FIRST_EN
    vec[0] = '{ncodes: 4'd2, codes: {12'h062, 12'h061, 12'h000}, nbytes: 4'd3,
               bytes: {8'h62, 8'h10, 8'h06, 8'h00, 8'h00}, mode: 2'd0};
    vec[1] = '{ncodes: 4'd1, codes: {12'h100, 12'h000, 12'h000}, nbytes: 4'd2,
               bytes: {8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, mode: 2'd0};
    vec[2] = '{ncodes: 4'd3, codes: {12'h062, 12'h061, 12'h06E}, nbytes: 4'd5,
               bytes: {8'h62, 8'h10, 8'h06, 8'h6E, 8'h00}, mode: 2'd1};
    vec[3] = '{ncodes: 4'd3, codes: {12'hFFF, 12'h001, 12'hABC}, nbytes: 4'd5,
               bytes: {8'hFF, 8'h1F, 8'h00, 8'hBC, 8'h0A}, mode: 2'd0};
`else
    vec[0] = '{ncodes: 4'd2, codes: {12'h062, 12'h061, 12'h000}, nbytes: 4'd3,
               bytes: {8'h06, 8'h20, 8'h61, 8'h00, 8'h00}, mode: 2'd0};
    vec[1] = '{ncodes: 4'd1, codes: {12'h100, 12'h000, 12'h000}, nbytes: 4'd2,
               bytes: {8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, mode: 2'd0};
    vec[2] = '{ncodes: 4'd3, codes: {12'h062, 12'h061, 12'h06E}, nbytes: 4'd5,
               bytes: {8'h06, 8'h20, 8'h61, 8'h06, 8'hE0}, mode: 2'd1};
    vec[3] = '{ncodes: 4'd3, codes: {12'hFFF, 12'h001, 12'hABC}, nbytes: 4'd5,
               bytes: {8'hFF, 8'hF0, 8'h01, 8'hAB, 8'hC0}, mode: 2'd0};
`endif

    resetDut();

    for (int v = 0; v < 4; v++) begin
      $display("[TB] vector %0d", v);
      runVector(v);
    end

    $display("[TB] code_last without code_valid");
    bus.code_last_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      checkOutput("stray_last_valid", {31'b0, bus.byte_valid_o}, 32'd0);
      checkOutput("stray_last_flag", {31'b0, bus.byte_last_o}, 32'd0);
      checkOutput("stray_last_ready", {31'b0, bus.code_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
    end
    bus.code_last_i = 1'b0;

    $display("[TB] first-byte latency");
    cq = '{12'h1A5};
    pushModel(cq);
    applyStimulus(12'h1A5, 1'b1);
    @(negedge clk_i);
    checkOutput("latency_valid", {31'b0, bus.byte_valid_o}, 32'd1);
    checkOutput("drain_code_ready", {31'b0, bus.code_ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    waitDrain();

    $display("[TB] random backpressure stream");
    cq.delete();
    for (int i = 0; i < 20; i++) cq.push_back(CODE_W'($urandom));
    pushModel(cq);
    toggle_mode = 2;
    for (int i = 0; i < 20; i++) applyStimulus(cq[i], i == 19);
    waitDrain();

    $display("[TB] reset mid-drain");
    cq.delete();
    for (int i = 0; i < 14; i++) cq.push_back(CODE_W'(i * 32'h123 + 7));
    pushModel(cq);
    for (int i = 0; i < 14; i++) applyStimulus(cq[i], i == 13);
    resetDut();
    runVector(0);

    $display("[TB] byte counter wrap");
    resetDut();
    for (int s = 0; s < WRAP_STREAMS; s++) begin
      cq.delete();
      cq.push_back(CODE_W'($urandom));
      cq.push_back(CODE_W'($urandom));
      pushModel(cq);
      applyStimulus(cq[0], 1'b0);
      applyStimulus(cq[1], 1'b1);
    end
    waitDrain();
    @(negedge clk_i);
    checkOutput("count_wrap", {22'b0, bus.byte_count_o}, (WRAP_STREAMS * 3) % (1 << CNT_W));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
